// File: rtl/contador_seq.sv
// contador_seq: drives the lab's 4-bit up/down counter through programmed runs,
// either a single run to a target or a continuous bounce between two limits.
`timescale 1ns/1ps
module contador_seq #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned PW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [NBITS-1:0] lo,
  input  logic [NBITS-1:0] hi,
  input  logic [PW-1:0]    period,
  input  logic [NBITS-1:0] cnt_q,
  output logic             cnt_up,
  output logic             cnt_down,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             dir,
  output logic [7:0]       bounces
);

  localparam int unsigned BW = 8;

  typedef enum logic [1:0] {IDLE, CHECK, STEP, WAIT} state_t;

  state_t           state, state_d;
  logic             mode_r, mode_d;
  logic [NBITS-1:0] lo_r, lo_d, hi_r, hi_d;
  logic [PW-1:0]    period_r, period_d;
  logic [PW-1:0]    wait_cnt, wait_d;
  logic             dir_d;
  logic [BW-1:0]    bounces_d;
  logic             done_d, err_d;
  logic             busy_d, cnt_up_d, cnt_down_d;
  logic [NBITS-1:0] goal;

  // Value the counter is currently heading for
  assign goal = dir ? hi_r : (mode_r ? lo_r : hi_r);

  // State, latched run configuration and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      lo_r     <= '0;
      hi_r     <= '0;
      period_r <= '0;
      wait_cnt <= '0;
      dir      <= 1'b0;
      bounces  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      cnt_up   <= 1'b0;
      cnt_down <= 1'b0;
    end else begin
      state    <= state_d;
      mode_r   <= mode_d;
      lo_r     <= lo_d;
      hi_r     <= hi_d;
      period_r <= period_d;
      wait_cnt <= wait_d;
      dir      <= dir_d;
      bounces  <= bounces_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= busy_d;
      cnt_up   <= cnt_up_d;
      cnt_down <= cnt_down_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state;
    mode_d    = mode_r;
    lo_d      = lo_r;
    hi_d      = hi_r;
    period_d  = period_r;
    wait_d    = wait_cnt;
    dir_d     = dir;
    bounces_d = bounces;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (mode && (lo > hi)) begin
            err_d = 1'b1;
          end else begin
            mode_d    = mode;
            lo_d      = lo;
            hi_d      = hi;
            period_d  = period;
            bounces_d = '0;
            dir_d     = (cnt_q < hi);
            state_d   = CHECK;
          end
        end
      end
      CHECK: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q != goal) begin
          state_d = STEP;
        end else if (!mode_r || (lo_r == hi_r)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          // Reached one limit in bounce mode: reverse, costs this one cycle
          dir_d = ~dir;
          if (bounces != {BW{1'b1}}) bounces_d = bounces + BW'(1);
        end
      end
      STEP: begin
        // The step pulse is already on the outputs, so a stop here still steps
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (period_r != '0) begin
          wait_d  = period_r;
          state_d = WAIT;
        end else begin
          state_d = CHECK;
        end
      end
      WAIT: begin
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (wait_cnt <= PW'(1)) begin
          state_d = CHECK;
        end else begin
          wait_d = wait_cnt - PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state
  always_comb begin
    busy_d     = (state_d != IDLE);
    cnt_up_d   = (state_d == STEP) && dir_d;
    cnt_down_d = (state_d == STEP) && !dir_d;
  end

endmodule

// File: tb/tb_contador_seq.sv
// Bench for contador_seq: a behavioural lab counter closes the loop, a driver
// launches directed runs and a negedge monitor scores done/err/probe events.
`timescale 1ns/1ps
module tb_contador_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, mode;
  logic [3:0] lo, hi;
  logic [7:0] period;
  logic [3:0] cnt;
  logic       cnt_up, cnt_down, busy, done, err, dir;
  logic [7:0] bounces;

  logic       load;
  logic [3:0] load_val;
  logic       probe_req;

  typedef struct {
    bit is_probe;
    bit is_err;
    int lat;
    int cnt;
    int steps;
    int bnc;
    int deadline;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   steps = 0;
  int   start_at = 0;
  bit   both = 1'b0;

  contador_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .lo       (lo),
    .hi       (hi),
    .period   (period),
    .cnt_q    (cnt),
    .cnt_up   (cnt_up),
    .cnt_down (cnt_down),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dir      (dir),
    .bounces  (bounces)
  );

  always #5 clk = ~clk;

  // Lab counter: preloadable, steps on the sequencer's requests, own state
  always @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (cnt_up) cnt <= cnt + 4'd1;
    else if (cnt_down) cnt <= cnt - 4'd1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset && start && !busy) begin
      steps    = 0;
      both     = 1'b0;
      start_at = cyc + 1;
    end
    if (cnt_up && cnt_down) both = 1'b1;
    if (busy && (cnt_up || cnt_down)) steps++;
    if (probe_req) begin
      if (exp_q.size() == 0) chk("probe_no_expectation", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("probe_kind", 1, int'(e.is_probe));
        chk("probe_outputs", int'({cnt_up, cnt_down, busy, done, err, dir, bounces}), 0);
      end
    end else if (done || err) begin
      if (exp_q.size() == 0) chk("unexpected_done_err", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("kind_err", int'(err), int'(e.is_err));
        chk("busy_at_end", int'(busy), 0);
        chk("final_cnt", int'(cnt), e.cnt);
        chk("steps", steps, e.steps);
        chk("bounces", int'(bounces), e.bnc);
        chk("up_down_both_high", int'(both), 0);
        if (e.lat >= 0) chk("latency", cyc - start_at + 1, e.lat);
      end
    end else if (exp_q.size() != 0 && !exp_q[0].is_probe && cyc > exp_q[0].deadline) begin
      e = exp_q.pop_front();
      chk("timeout_waiting_done", 1, 0);
    end
  end

  task automatic push(input bit is_probe, input bit is_err, input int lat,
                      input int c, input int s, input int b);
    exp_t e;
    e.is_probe = is_probe;
    e.is_err   = is_err;
    e.lat      = lat;
    e.cnt      = c;
    e.steps    = s;
    e.bnc      = b;
    e.deadline = cyc + 300;
    exp_q.push_back(e);
  endtask

  task automatic preload(input int v);
    @(posedge clk); #1;
    load = 1'b1;
    load_val = 4'(v);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic start_run(input int m, input int l, input int h, input int p);
    @(posedge clk); #1;
    mode   = 1'(m);
    lo     = 4'(l);
    hi     = 4'(h);
    period = 8'(p);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic probe();
    push(1'b1, 1'b0, -1, 0, 0, 0);
    probe_req = 1'b1;
    @(negedge clk); #1;
    probe_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    lo = '0; hi = '0; period = '0; load = 1'b0; load_val = '0; probe_req = 1'b0;
    probe();
    @(posedge clk); #1;
    reset = 1'b0;

    // Single run up 3 -> 5, period 0
    preload(3);
    push(1'b0, 1'b0, 6, 5, 2, 0);
    start_run(0, 0, 5, 0);
    drain();

    // Single run down 12 -> 9, period 2
    preload(12);
    push(1'b0, 1'b0, 14, 9, 3, 0);
    start_run(0, 0, 9, 2);
    drain();

    // Bounce 2..4, stopped in CHECK after the third reversal (at 4)
    preload(2);
    push(1'b0, 1'b0, -1, 4, 6, 3);
    start_run(1, 2, 4, 0);
    for (int i = 0; i < 100 && bounces != 8'd3; i++) begin
      @(posedge clk); #1;
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    drain();

    // Rejected bounce start: lo > hi; bounces from previous run untouched
    push(1'b0, 1'b1, 1, 4, 0, 3);
    start_run(1, 7, 3, 0);
    drain();

    // Start while busy is ignored; latched hi stays 3
    preload(0);
    push(1'b0, 1'b0, 11, 3, 3, 0);
    start_run(0, 0, 3, 1);
    @(posedge clk); #1;
    mode = 1'b1; lo = 4'd9; hi = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();

    // Already at target in single mode
    preload(7);
    push(1'b0, 1'b0, 2, 7, 0, 0);
    start_run(0, 0, 7, 0);
    drain();

    // Bounce with lo == hi == 6 from 4
    preload(4);
    push(1'b0, 1'b0, 6, 6, 2, 0);
    start_run(1, 6, 6, 0);
    drain();

    // Reset during WAIT: outputs clear without a clock edge, no done pulse
    preload(0);
    start_run(0, 0, 2, 5);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    probe();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Fresh run after reset; counter held at 1
    push(1'b0, 1'b0, 9, 2, 1, 0);
    start_run(0, 0, 2, 5);
    drain();

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover_expectations: got %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/contador_seq.md
# contador_seq

Sequencer for the 4-bit synchronous up/down counter in the counter lab.
- It drives the counter's `counter_up` and `counter_down` inputs and watches its `Saida` output to run programmed count sequences.
- Two modes: a single run to a target value, or a continuous bounce between a low and a high limit.
- Step spacing is set by a programmable prescaler.
- A start/busy/done handshake lets a test FSM or a top-level board wrapper launch and observe runs.

## Interface
- `NBITS`, default 4: width of the counter value and of `lo`/`hi`.
- `PW`, default 8: width of `period`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: launch a run. Sampled only in IDLE.
- `stop` in 1: abort a run. Sampled only when not in IDLE.
- `mode` in 1: 0 = single run to `hi`; 1 = bounce between `lo` and `hi`.
- `lo` in NBITS: lower limit, bounce mode only.
- `hi` in NBITS: target value / upper limit.
- `period` in PW: extra wait cycles inserted after each step.
- `cnt_q` in NBITS: current counter value (the counter's `Saida`).
- `cnt_up` out 1: step request to the counter, count up.
- `cnt_down` out 1: step request to the counter, count down.
- `busy` out 1: high while the FSM is not in IDLE.
- `done` out 1: one-cycle pulse when a run ends, normally or by `stop`.
- `err` out 1: one-cycle pulse when a start is rejected.
- `dir` out 1: current direction, 1 = up.
- `bounces` out 8: number of reversals in the current run, saturating at 255.

## Operation
- **Registers:** state, `dir`, the latched config (`mode_r`, `lo_r`, `hi_r`, `period_r`), `wait_cnt`, `bounces`, `done`, `err`.
- **States:** IDLE, CHECK, STEP, WAIT.
- **IDLE + `start`:**
  - If `mode=1` and `lo>hi`: pulse `err`, stay in IDLE.
  - Otherwise: latch `mode`, `lo`, `hi`, `period`; clear `bounces`; set `dir = (cnt_q < hi)`; go to CHECK.
- **Goal:** `hi_r` when `dir=1`; `lo_r` when `dir=0` and `mode_r=1`; `hi_r` when `dir=0` and `mode_r=0`.
- **CHECK:**
  - If `cnt_q != goal`: go to STEP.
  - If `cnt_q == goal` and `mode_r=0`: go to IDLE, pulse `done`.
  - If `cnt_q == goal` and `mode_r=1` and `lo_r==hi_r`: go to IDLE, pulse `done`.
  - If `cnt_q == goal` and `mode_r=1` otherwise: toggle `dir`, increment `bounces` (saturating), stay in CHECK.
- **STEP:** lasts one cycle.
  - `cnt_up = dir`, `cnt_down = ~dir`. Both are decoded from registered state, so they are glitch-free and never both high.
  - Exit to WAIT with `wait_cnt = period_r` if `period_r != 0`; otherwise exit to CHECK.
- **WAIT:** decrement `wait_cnt`; go to CHECK when it reaches 1.
- **`stop` in any non-IDLE state:** go to IDLE at the next edge and pulse `done`.
  - If `stop` arrives in the STEP cycle, that step still takes effect.
- **IDLE:** `stop` is ignored. If `start` and `stop` are high together in IDLE, `start` wins.
- **While busy:** `start` is ignored. Changes on `lo`, `hi`, `mode`, `period` have no effect until the next start.
- **No wrap-around:** the goal always lies in the direction of travel, so the counter never wraps.
- **Lockout:** the counter must not be driven by any other source while `busy=1`.

## Timing
- **Reset values:** state IDLE; `cnt_up`, `cnt_down`, `busy`, `done`, `err`, `dir` all 0; `bounces` 0. Reset mid-run aborts immediately with no `done` pulse.
- **Start:** `start` sampled at edge k → CHECK in cycle k+1, and `busy` is high from k+1.
- **Step spacing:** a step issued in cycle t appears on `cnt_q` in t+1. Steps are spaced `period+2` cycles apart: CHECK, STEP, then `period` WAIT cycles.
- **Done:** `done` and `busy=0` appear in the cycle after the final CHECK.
- **Single-run latency:** distance d > 0 takes `2 + d·(period+2)` cycles from the start edge to `done`.
- **Already at target:** if the counter already equals `hi` at start (d = 0), `done` arrives 2 cycles after start and no step is issued.
- **Reversal:** costs exactly 1 extra CHECK cycle.

## Test plan
- **Single run up:** `cnt_q=3`, `hi=5`, `period=0`, start at edge 0 → `cnt_up` high in cycles 2 and 4; `done` in cycle 6; counter ends at 5.
- **Single run down:** `cnt_q=12`, `hi=9`, `period=2` → three `cnt_down` pulses spaced 4 cycles apart; counter ends at 9; `done` after `2+3·4=14` cycles.
- **Bounce:** `lo=2`, `hi=4`, `cnt_q=2`, `period=0` → counter sequence 2,3,4,3,2,3,…; `bounces` increments at each 4 and each 2. `stop` asserted → IDLE at the next edge with a `done` pulse; the counter holds its value.
- **Rejected starts:** bounce start with `lo=7`, `hi=3` → `err` pulse, `busy` stays 0, no steps. Start while busy → ignored, and the latched `hi` is unchanged.
- **Degenerate cases:** `cnt_q=hi` at start in single mode → `done` 2 cycles after start, zero steps. Bounce with `lo=hi=6` starting from `cnt_q=4` → steps up to 6, then `done`.
- **Reset mid-WAIT:** with `period=5`, assert `reset` during WAIT → all outputs 0 immediately; a new start then runs normally.
